trap_controller: RTL and testbench

Machine-mode trap/interrupt sequencer for the RV32IC core. Owns the machine CSRs: mepc, mcycle, mtime, minstret, mtimecmp, mie, mip. Arbitrates NMI, ecall/ebreak, external and timer causes, saves the PC, redirects fetch to the handler vector, and returns on mret. Sits beside the execute stage; the pipeline treats it as a redirect source.

---
 rtl/trap_controller.sv | 183 ++++++++++++++++++
 tb/tb_trap_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer for the RV32IC core: owns the M-mode CSRs, arbitrates
// trap causes and redirects fetch into the handler vector and back again on mret.
module trap_controller #(
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0100,
  parameter int unsigned TIME_DIV     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] pc_in,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        nmi,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        in_handler
);

  localparam int unsigned   PW       = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TIME_DIV - 1);

  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MTIME    = 12'hB01;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MTIMECMP = 12'hB03;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [1:0] CAUSE_NMI   = 2'd0;
  localparam logic [1:0] CAUSE_ENV   = 2'd1;
  localparam logic [1:0] CAUSE_EXT   = 2'd2;
  localparam logic [1:0] CAUSE_TIMER = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    HANDLER,
    RETURN
  } state_t;

  state_t state, state_next;

  logic [31:0]   mepc, mcycle, mtime, minstret, mtimecmp;
  logic [3:0]    mie;
  logic          mip_ext, mip_env, nmi_pend;
  logic [PW-1:0] prescaler;
  logic [1:0]    cause;

  logic        timer_level, mtime_tick;
  logic        nmi_req, env_req, ext_req, tmr_req, trap_accept;
  logic [1:0]  trap_cause;
  logic        env_set, env_clr, ext_set;
  logic        wr_mepc, wr_mcycle, wr_mtime, wr_minstret, wr_mtimecmp, wr_mie, wr_mip;
  logic [31:0] read_value;

  assign timer_level = (mtimecmp != 32'd0) && (mtime >= mtimecmp);
  assign mtime_tick  = (prescaler == PRE_LAST);

  // NMI is taken from the live pulse as well as the latch, so a pulse on an
  // eligible cycle never has to wait a cycle in nmi_pend.
  assign nmi_req = nmi | nmi_pend;
  assign env_req = mie[3] & mie[2] & (ecall | ebreak);
  assign ext_req = mie[3] & mie[1] & (ext_irq | mip_ext);
  assign tmr_req = mie[3] & mie[0] & timer_level;

  assign trap_accept = (state == IDLE) && instr_valid &&
                       (nmi_req || env_req || ext_req || tmr_req);

  always_comb begin
    trap_cause = CAUSE_TIMER;
    if (nmi_req)      trap_cause = CAUSE_NMI;
    else if (env_req) trap_cause = CAUSE_ENV;
    else if (ext_req) trap_cause = CAUSE_EXT;
  end

  assign env_set = trap_accept && (trap_cause == CAUSE_ENV);
  assign ext_set = trap_accept && (trap_cause == CAUSE_EXT);
  assign env_clr = (state == RETURN) && (cause == CAUSE_ENV);

  assign wr_mepc     = csr_we && (csr_addr == ADDR_MEPC);
  assign wr_mcycle   = csr_we && (csr_addr == ADDR_MCYCLE);
  assign wr_mtime    = csr_we && (csr_addr == ADDR_MTIME);
  assign wr_minstret = csr_we && (csr_addr == ADDR_MINSTRET);
  assign wr_mtimecmp = csr_we && (csr_addr == ADDR_MTIMECMP);
  assign wr_mie      = csr_we && (csr_addr == ADDR_MIE);
  assign wr_mip      = csr_we && (csr_addr == ADDR_MIP);

  always_comb begin
    read_value = 32'd0;
    case (csr_addr)
      ADDR_MEPC:     read_value = mepc;
      ADDR_MCYCLE:   read_value = mcycle;
      ADDR_MTIME:    read_value = mtime;
      ADDR_MINSTRET: read_value = minstret;
      ADDR_MTIMECMP: read_value = mtimecmp;
      ADDR_MIE:      read_value = {28'd0, mie};
      ADDR_MIP:      read_value = {29'd0, mip_env, mip_ext, timer_level};
      default:       read_value = 32'd0;
    endcase
  end

  always_comb begin
    state_next  = state;
    pc_redirect = 1'b0;
    redirect_pc = 32'd0;
    in_handler  = 1'b0;
    case (state)
      IDLE: begin
        if (trap_accept) state_next = TAKE;
      end
      TAKE: begin
        pc_redirect = 1'b1;
        redirect_pc = HANDLER_BASE + {28'd0, cause, 2'b00};
        state_next  = HANDLER;
      end
      HANDLER: begin
        in_handler = 1'b1;
        if (instr_valid && mret) state_next = RETURN;
      end
      RETURN: begin
        pc_redirect = 1'b1;
        redirect_pc = mepc;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      csr_rdata <= 32'd0;
      mepc      <= 32'd0;
      mcycle    <= 32'd0;
      mtime     <= 32'd0;
      minstret  <= 32'd0;
      mtimecmp  <= 32'd0;
      mie       <= 4'd0;
      mip_ext   <= 1'b0;
      mip_env   <= 1'b0;
      nmi_pend  <= 1'b0;
      prescaler <= '0;
      cause     <= CAUSE_NMI;
    end else begin
      state     <= state_next;
      csr_rdata <= read_value;

      // Software writes override the same-cycle hardware increments.
      mcycle    <= wr_mcycle ? csr_wdata : mcycle + 32'd1;
      prescaler <= mtime_tick ? '0 : prescaler + 1'b1;

      if (wr_mtime)        mtime <= csr_wdata;
      else if (mtime_tick) mtime <= mtime + 32'd1;

      if (wr_minstret)                       minstret <= csr_wdata;
      else if (instr_valid && !trap_accept)  minstret <= minstret + 32'd1;

      if (wr_mtimecmp) mtimecmp <= csr_wdata;
      if (wr_mie)      mie      <= csr_wdata[3:0];

      if (trap_accept) begin
        mepc  <= pc_in;
        cause <= trap_cause;
      end else if (wr_mepc) begin
        mepc <= csr_wdata;
      end

      nmi_pend <= (trap_accept && (trap_cause == CAUSE_NMI)) ? 1'b0 : (nmi_pend | nmi);

      // Software may only clear pending bits; any hardware set in the same cycle wins.
      mip_ext <= ext_irq | ext_set | (wr_mip ? (mip_ext & csr_wdata[1]) : mip_ext);
      mip_env <= env_set | (~env_clr & (wr_mip ? (mip_env & csr_wdata[2]) : mip_env));
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: hand-computed vectors plus a cycle-level
// reference model of the trap sequencer checked against the DUT every cycle.
module tb_trap_controller;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int unsigned TD   = 8;

  logic        clk = 1'b0;
  logic        rst, instr_valid, ecall, ebreak, mret, ext_irq, nmi, csr_we;
  logic [31:0] pc_in, csr_wdata, csr_rdata, redirect_pc;
  logic [11:0] csr_addr;
  logic        pc_redirect, in_handler;

  int checks = 0;
  int errors = 0;

  trap_controller #(.HANDLER_BASE(BASE), .TIME_DIV(TD)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_in(pc_in),
    .ecall(ecall), .ebreak(ebreak), .mret(mret), .ext_irq(ext_irq), .nmi(nmi),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: counters are derived from edge counts since reset/last write,
  // the trap sequence is tracked as a phase 0=idle 1=to-handler 2=handler 3=back.
  int unsigned edges, mcyc_at, mtime_at;
  logic [31:0] m_mepc, m_minstret, m_mtimecmp, mcyc_base, mtime_base, exp_rdata;
  logic [3:0]  m_mie;
  bit          m_ext, m_env, m_nmi, live = 1'b0;
  int          m_cause, phase;

  function automatic logic [31:0] m_mcycle();
    return mcyc_base + 32'(edges - mcyc_at);
  endfunction

  function automatic logic [31:0] m_mtime();
    return mtime_base + 32'(edges / TD - mtime_at / TD);
  endfunction

  function automatic bit m_timer();
    return (m_mtimecmp != 32'd0) && (m_mtime() >= m_mtimecmp);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h341: return m_mepc;
      12'hB00: return m_mcycle();
      12'hB01: return m_mtime();
      12'hB02: return m_minstret;
      12'hB03: return m_mtimecmp;
      12'h304: return {28'd0, m_mie};
      12'h344: return {29'd0, m_env, m_ext, m_timer()};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      edges = 0; mcyc_at = 0; mtime_at = 0;
      m_mepc = 0; m_minstret = 0; m_mtimecmp = 0; mcyc_base = 0; mtime_base = 0;
      exp_rdata = 0; m_mie = 0; m_ext = 0; m_env = 0; m_nmi = 0;
      m_cause = 0; phase = 0; live = 1'b1;
    end else begin
      int c;
      bit ret_env;
      exp_rdata = m_read(csr_addr);
      c = -1;
      if (phase == 0 && instr_valid) begin
        if (m_nmi || nmi)                                      c = 0;
        else if (m_mie[3] && m_mie[2] && (ecall || ebreak))    c = 1;
        else if (m_mie[3] && m_mie[1] && (m_ext || ext_irq))   c = 2;
        else if (m_mie[3] && m_mie[0] && m_timer())            c = 3;
      end
      ret_env = (phase == 3) && (m_cause == 1);
      edges++;
      if (instr_valid && c < 0) m_minstret = m_minstret + 1;
      if (csr_we) begin
        case (csr_addr)
          12'h341: m_mepc = csr_wdata;
          12'hB00: begin mcyc_base = csr_wdata; mcyc_at = edges; end
          12'hB01: begin mtime_base = csr_wdata; mtime_at = edges; end
          12'hB02: m_minstret = csr_wdata;
          12'hB03: m_mtimecmp = csr_wdata;
          12'h304: m_mie = csr_wdata[3:0];
          12'h344: begin m_ext = m_ext & csr_wdata[1]; m_env = m_env & csr_wdata[2]; end
          default: ;
        endcase
      end
      m_ext = m_ext | ext_irq;
      if (ret_env) m_env = 0;
      m_nmi = (c == 0) ? 1'b0 : (m_nmi | nmi);
      if (c >= 0) begin
        phase = 1; m_cause = c; m_mepc = pc_in;
        if (c == 1) m_env = 1;
      end else begin
        case (phase)
          1: phase = 2;
          2: if (instr_valid && mret) phase = 3;
          3: phase = 0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      checkOutput("model csr_rdata", csr_rdata, exp_rdata);
      checkOutput("model pc_redirect", {31'd0, pc_redirect}, {31'd0, (phase == 1 || phase == 3)});
      checkOutput("model redirect_pc", redirect_pc,
                  (phase == 1) ? BASE + 32'(4 * m_cause) : (phase == 3) ? m_mepc : 32'd0);
      checkOutput("model in_handler", {31'd0, in_handler}, {31'd0, phase == 2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic ec,
                               input logic mr, input logic ext, input logic n);
    instr_valid = iv; pc_in = pc; ecall = ec; ebreak = 1'b0;
    mret = mr; ext_irq = ext; nmi = n;
  endtask

  task automatic csrWrite(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic readCsr(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    tick();
    d = csr_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    int hits;
    bit found;
    rst = 1'b1; csr_we = 1'b0; csr_addr = 12'hB01; csr_wdata = 32'd0;
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset pc_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("reset redirect_pc", redirect_pc, 32'd0);
    checkOutput("reset csr_rdata", csr_rdata, 32'd0);

    // Idle counting
    repeat (20) tick();
    readCsr(12'hB00, rd); checkOutput("idle mcycle", rd, 32'd20);
    readCsr(12'hB01, rd); checkOutput("idle mtime", rd, 32'd2);
    readCsr(12'hB03, rd); checkOutput("idle mtimecmp", rd, 32'd0);

    // ecall round trip
    csrWrite(12'h304, 32'hF);
    applyStimulus(1, 32'h40, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    checkOutput("ecall redirect", {31'd0, pc_redirect}, 32'd1);
    checkOutput("ecall vector", redirect_pc, 32'h104);
    tick();
    checkOutput("ecall in_handler", {31'd0, in_handler}, 32'd1);
    readCsr(12'h341, rd); checkOutput("ecall mepc", rd, 32'h40);
    readCsr(12'h344, rd); checkOutput("ecall mip", rd, 32'h4);
    readCsr(12'hB02, rd); checkOutput("ecall minstret", rd, 32'd0);
    applyStimulus(1, 32'h1F0, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    checkOutput("mret target", redirect_pc, 32'h40);
    tick();
    readCsr(12'h344, rd); checkOutput("mret mip clear", rd, 32'h0);
    readCsr(12'hB02, rd); checkOutput("mret retired", rd, 32'd1);

    // Timer interrupt
    csrWrite(12'hB01, 32'd0);
    csrWrite(12'hB03, 32'd5);
    csrWrite(12'h304, 32'h9);
    applyStimulus(1, 32'h200, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (pc_redirect) found = 1'b1;
    end
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    checkOutput("timer taken", {31'd0, found}, 32'd1);
    checkOutput("timer vector", redirect_pc, 32'h10C);
    tick();
    csrWrite(12'h304, 32'h1);
    applyStimulus(1, 32'h2F0, 0, 1, 0, 0);
    tick();
    checkOutput("timer return", redirect_pc, 32'h200);
    applyStimulus(1, 32'h204, 0, 0, 0, 0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pc_redirect) hits++;
    end
    checkOutput("timer masked", hits, 32'd0);
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    readCsr(12'h344, rd); checkOutput("timer level mip", rd, 32'h1);

    // NMI beats external, second NMI held through the handler
    csrWrite(12'h304, 32'h0);
    applyStimulus(1, 32'h300, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    checkOutput("nmi vector", redirect_pc, 32'h100);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    tick();
    checkOutput("nmi held", {31'd0, in_handler}, 32'd1);
    applyStimulus(1, 32'h310, 0, 1, 0, 0);
    tick();
    checkOutput("nmi return", redirect_pc, 32'h300);
    applyStimulus(1, 32'h314, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    checkOutput("nmi2 redirect", {31'd0, pc_redirect}, 32'd1);
    checkOutput("nmi2 vector", redirect_pc, 32'h100);
    tick();
    applyStimulus(1, 32'h320, 0, 1, 0, 0);
    tick();
    checkOutput("nmi2 return", redirect_pc, 32'h314);
    applyStimulus(1, 32'h318, 0, 0, 0, 0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pc_redirect) hits++;
    end
    checkOutput("ext masked", hits, 32'd0);
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    readCsr(12'h344, rd); checkOutput("ext sticky", rd, 32'h3);
    csrWrite(12'h344, 32'h0);
    readCsr(12'h344, rd); checkOutput("mip sw clear", rd, 32'h1);
    csrWrite(12'h344, 32'hFFFF_FFFF);
    readCsr(12'h344, rd); checkOutput("mip sw no set", rd, 32'h1);

    // Counter wrap and write priority
    csrWrite(12'hB02, 32'hFFFF_FFFF);
    applyStimulus(1, 32'h400, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    readCsr(12'hB02, rd); checkOutput("minstret wrap", rd, 32'd0);
    csrWrite(12'hB00, 32'h1234_5678);
    readCsr(12'hB00, rd); checkOutput("mcycle write", rd, 32'h1234_5678);
    csrWrite(12'h7C0, 32'hDEAD_BEEF);
    readCsr(12'h7C0, rd); checkOutput("unmapped", rd, 32'd0);
    csrWrite(12'h304, 32'hFFFF_FFF0);
    readCsr(12'h304, rd); checkOutput("mie upper", rd, 32'd0);
    csrWrite(12'hB03, 32'd7);
    checkOutput("read before write", csr_rdata, 32'd5);

    // Reset in the middle of a trap
    csrWrite(12'h304, 32'hF);
    applyStimulus(1, 32'h80, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    rst = 1'b1;
    checkOutput("pre-reset take", {31'd0, pc_redirect}, 32'd1);
    tick();
    rst = 1'b0;
    checkOutput("reset abort redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("reset abort handler", {31'd0, in_handler}, 32'd0);
    readCsr(12'h341, rd); checkOutput("reset mepc", rd, 32'd0);
    readCsr(12'h304, rd); checkOutput("reset mie", rd, 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
